// File: rtl/pw_trigger_monitor.sv
// pw_trigger_monitor: measures a trigger pulse train on I_pulse.
// For up to pNUM_PULSES pulses it records the low time before each rising
// edge and the high time of each pulse, in trigger_clk cycles.
// Optional feature macro: PW_TRIGGER_MONITOR_GLITCH_FILTER_EN. When it is
// defined, I_pulse must hold a new level for 2 cycles before it is seen, and
// I_start is delayed by the same 2 cycles so that clean pulses measure the same.
module pw_trigger_monitor #(
  parameter int pNUM_PULSES  = 8,
  parameter int pNUM_WIDTH   = 4,
  parameter int pCOUNT_WIDTH = 20
) (
  input  logic                      trigger_clk,
  input  logic                      reset_n,
  input  logic                      I_pulse,
  input  logic                      I_start,
  input  logic                      I_arm,
  input  logic [pNUM_WIDTH-1:0]     I_num_pulses,
  output logic [24*pNUM_PULSES-1:0] O_delay,
  output logic [24*pNUM_PULSES-1:0] O_width,
  output logic [pNUM_WIDTH-1:0]     O_pulse_count,
  output logic                      O_busy,
  output logic                      O_done,
  output logic                      O_overflow
);

  localparam int                      IDX_W      = (pNUM_PULSES > 1) ? $clog2(pNUM_PULSES) : 1;
  localparam logic [pNUM_WIDTH-1:0]   MAX_PULSES = pNUM_WIDTH'(pNUM_PULSES);
  localparam logic [pCOUNT_WIDTH-1:0] CNT_MAX    = {pCOUNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_MEAS_LOW   = 3'd2,
    S_MEAS_HIGH  = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    pulse_q;
  logic                    arm_q;
  logic                    start_s;
  logic                    arm_rise_s;
  logic                    last_s;
  logic                    cnt_sat_s;
  logic [pCOUNT_WIDTH-1:0] cnt_q;
  logic [pCOUNT_WIDTH-1:0] cnt_inc_s;
  logic [IDX_W-1:0]        idx_q;
  logic [pNUM_WIDTH-1:0]   idx_next_s;
  logic [pNUM_WIDTH-1:0]   limit_q;
  logic [pNUM_WIDTH-1:0]   limit_s;
  logic [pNUM_WIDTH-1:0]   count_q;
  logic                    overflow_q;
  logic [pCOUNT_WIDTH-1:0] delay_q [pNUM_PULSES];
  logic [pCOUNT_WIDTH-1:0] width_q [pNUM_PULSES];

`ifdef PW_TRIGGER_MONITOR_GLITCH_FILTER_EN
  logic       pulse_a_q;
  logic       pulse_b_q;
  logic [1:0] start_dly_q;

  // Two-sample agreement filter on I_pulse; start delayed to keep alignment
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_a_q   <= 1'b0;
      pulse_b_q   <= 1'b0;
      pulse_q     <= 1'b0;
      start_dly_q <= 2'b00;
    end else begin
      pulse_a_q   <= I_pulse;
      pulse_b_q   <= pulse_a_q;
      start_dly_q <= {start_dly_q[0], I_start};
      if (pulse_a_q == pulse_b_q) begin
        pulse_q <= pulse_a_q;
      end
    end
  end

  assign start_s = start_dly_q[1];
`else
  // Single register stage on I_pulse
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= I_pulse;
    end
  end

  assign start_s = I_start;
`endif

  // Previous-cycle I_arm for rising-edge detection
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= I_arm;
    end
  end

  // Arm edge, clamped pulse limit, saturating increment and last-pulse test
  always_comb begin
    arm_rise_s = I_arm & ~arm_q;
    if (I_num_pulses == '0) begin
      limit_s = pNUM_WIDTH'(1);
    end else if (I_num_pulses > MAX_PULSES) begin
      limit_s = MAX_PULSES;
    end else begin
      limit_s = I_num_pulses;
    end
    idx_next_s = pNUM_WIDTH'(idx_q) + pNUM_WIDTH'(1);
    last_s     = (idx_next_s == limit_q);
    cnt_sat_s  = (cnt_q == CNT_MAX);
    if (cnt_sat_s) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + pCOUNT_WIDTH'(1);
    end
  end

  // FSM state register
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping I_arm aborts from any active state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arm_rise_s) state_d = S_WAIT_START;
        else            state_d = S_IDLE;
      end
      S_WAIT_START: begin
        if (!I_arm)       state_d = S_IDLE;
        else if (start_s) state_d = S_MEAS_LOW;
        else              state_d = S_WAIT_START;
      end
      S_MEAS_LOW: begin
        if (!I_arm)       state_d = S_IDLE;
        else if (pulse_q) state_d = S_MEAS_HIGH;
        else              state_d = S_MEAS_LOW;
      end
      S_MEAS_HIGH: begin
        if (!I_arm)        state_d = S_IDLE;
        else if (pulse_q)  state_d = S_MEAS_HIGH;
        else if (last_s)   state_d = S_DONE;
        else               state_d = S_MEAS_LOW;
      end
      S_DONE: begin
        if (!I_arm) state_d = S_IDLE;
        else        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    O_busy = 1'b0;
    O_done = 1'b0;
    case (state_q)
      S_WAIT_START, S_MEAS_LOW, S_MEAS_HIGH: O_busy = 1'b1;
      S_DONE:                                O_done = 1'b1;
      default: begin
        O_busy = 1'b0;
        O_done = 1'b0;
      end
    endcase
  end

  // Measurement datapath: counter, slot index, result slots, count, overflow
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      limit_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < pNUM_PULSES; k++) begin
        delay_q[k] <= '0;
        width_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_rise_s) begin
            limit_q    <= limit_s;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < pNUM_PULSES; k++) begin
              delay_q[k] <= '0;
              width_q[k] <= '0;
            end
          end
        end
        S_WAIT_START: begin
          if (I_arm && start_s) begin
            cnt_q <= '0;
            idx_q <= '0;
          end
        end
        S_MEAS_LOW: begin
          if (I_arm) begin
            if (pulse_q) begin
              delay_q[idx_q] <= cnt_q;
              cnt_q          <= pCOUNT_WIDTH'(1);
            end else begin
              cnt_q <= cnt_inc_s;
              if (cnt_sat_s) overflow_q <= 1'b1;
            end
          end
        end
        S_MEAS_HIGH: begin
          if (I_arm) begin
            if (!pulse_q) begin
              // the falling-edge cycle is the first low cycle of the next delay
              width_q[idx_q] <= cnt_q;
              cnt_q          <= pCOUNT_WIDTH'(1);
              count_q        <= idx_next_s;
              if (!last_s) idx_q <= idx_q + IDX_W'(1);
            end else begin
              cnt_q <= cnt_inc_s;
              if (cnt_sat_s) overflow_q <= 1'b1;
            end
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // Pack result slots into 24-bit zero-extended fields
  always_comb begin
    O_delay = '0;
    O_width = '0;
    for (int k = 0; k < pNUM_PULSES; k++) begin
      O_delay[k*24 +: 24] = 24'(delay_q[k]);
      O_width[k*24 +: 24] = 24'(width_q[k]);
    end
  end

  assign O_pulse_count = count_q;
  assign O_overflow    = overflow_q;

endmodule
